// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin arbiter sharing one memory port between the
//               instruction-fetch (ifu) and load/store (lsu) requesters.
//               Issues one request pulse downstream per grant and routes the
//               response back to the owner, dropping responses for requests
//               withdrawn while in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ifu_reqValid,
    input  logic [ADDR_W-1:0]     ifu_addr,
    output logic                  ifu_respValid,
    output logic [DATA_W-1:0]     ifu_rdata,
    input  logic                  lsu_reqValid,
    input  logic [ADDR_W-1:0]     lsu_addr,
    input  logic                  lsu_wen,
    input  logic [DATA_W-1:0]     lsu_wdata,
    input  logic [DATA_W/8-1:0]   lsu_wmask,
    output logic                  lsu_respValid,
    output logic [DATA_W-1:0]     lsu_rdata,
    output logic                  mem_reqValid,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_wen,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wmask,
    input  logic                  mem_respValid,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  busy,
    output logic                  owner
);

    localparam int c_MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_owner;
    logic                  r_last_grant;
    logic                  r_aborted;
    logic [ADDR_W-1:0]     r_mem_addr;
    logic                  r_mem_wen;
    logic [DATA_W-1:0]     r_mem_wdata;
    logic [c_MASK_W-1:0]   r_mem_wmask;

    logic                  w_any_req;
    logic                  w_grant_lsu;
    logic                  w_owner_req;
    logic                  w_mem_req;
    logic                  w_ifu_resp;
    logic                  w_lsu_resp;
    logic                  w_abort_now;

    // Round-robin pick: lsu wins only when it is alone or ifu was served last.
    always_comb begin
        w_any_req   = ifu_reqValid | lsu_reqValid;
        w_grant_lsu = lsu_reqValid & (~ifu_reqValid | ~r_last_grant);
        w_owner_req = r_owner ? lsu_reqValid : ifu_reqValid;
    end

    // Next-state decode plus the single-cycle strobes derived from the state.
    always_comb begin
        w_state_next = r_state;
        w_mem_req    = 1'b0;
        w_ifu_resp   = 1'b0;
        w_lsu_resp   = 1'b0;
        w_abort_now  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_mem_req    = 1'b1;
                w_abort_now  = ~w_owner_req;
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (mem_respValid) begin
                    // The response is consumed even when the owner walked away.
                    w_state_next = S_IDLE;
                    w_ifu_resp   = ~r_aborted & ~r_owner;
                    w_lsu_resp   = ~r_aborted &  r_owner;
                end else begin
                    w_abort_now  = ~w_owner_req;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Transaction registers: payload latched on grant, owner history and abort flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_owner      <= 1'b1;
            r_last_grant <= 1'b1;
            r_aborted    <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wen    <= 1'b0;
            r_mem_wdata  <= '0;
            r_mem_wmask  <= '0;
        end else begin
            if (r_state == S_IDLE && w_any_req) begin
                r_owner     <= w_grant_lsu;
                r_aborted   <= 1'b0;
                r_mem_addr  <= w_grant_lsu ? lsu_addr : ifu_addr;
                r_mem_wen   <= w_grant_lsu & lsu_wen;
                r_mem_wdata <= w_grant_lsu ? lsu_wdata : '0;
                r_mem_wmask <= w_grant_lsu ? lsu_wmask : '0;
            end
            if (w_abort_now) begin
                r_aborted <= 1'b1;
            end
            if (r_state == S_WAIT && mem_respValid) begin
                r_last_grant <= r_owner;
            end
        end
    end

    assign mem_reqValid  = w_mem_req;
    assign mem_addr      = r_mem_addr;
    assign mem_wen       = r_mem_wen;
    assign mem_wdata     = r_mem_wdata;
    assign mem_wmask     = r_mem_wmask;
    assign ifu_respValid = w_ifu_resp;
    assign lsu_respValid = w_lsu_resp;
    assign ifu_rdata     = mem_rdata;
    assign lsu_rdata     = mem_rdata;
    assign busy          = (r_state != S_IDLE);
    assign owner         = r_owner;

`ifndef SYNTHESIS
    // Protocol sanity: strobes only in WAIT, downstream pulse only in ISSUE.
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (!(ifu_respValid || lsu_respValid) || r_state == S_WAIT);
            assert (!mem_reqValid || r_state == S_ISSUE);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Scoreboard bench for mem_arbiter: a transaction-level model
//               predicts downstream issues and requester responses, a monitor
//               pops and compares them as the DUT presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MASK_W = DATA_W / 8;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                ifu_reqValid = 1'b0;
    logic [ADDR_W-1:0]   ifu_addr = '0;
    logic                ifu_respValid;
    logic [DATA_W-1:0]   ifu_rdata;
    logic                lsu_reqValid = 1'b0;
    logic [ADDR_W-1:0]   lsu_addr = '0;
    logic                lsu_wen = 1'b0;
    logic [DATA_W-1:0]   lsu_wdata = '0;
    logic [MASK_W-1:0]   lsu_wmask = '0;
    logic                lsu_respValid;
    logic [DATA_W-1:0]   lsu_rdata;
    logic                mem_reqValid;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_wen;
    logic [DATA_W-1:0]   mem_wdata;
    logic [MASK_W-1:0]   mem_wmask;
    logic                mem_respValid = 1'b0;
    logic [DATA_W-1:0]   mem_rdata = '0;
    logic                busy;
    logic                owner;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock(clock), .reset(reset),
        .ifu_reqValid(ifu_reqValid), .ifu_addr(ifu_addr),
        .ifu_respValid(ifu_respValid), .ifu_rdata(ifu_rdata),
        .lsu_reqValid(lsu_reqValid), .lsu_addr(lsu_addr), .lsu_wen(lsu_wen),
        .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_respValid(lsu_respValid), .lsu_rdata(lsu_rdata),
        .mem_reqValid(mem_reqValid), .mem_addr(mem_addr), .mem_wen(mem_wen),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_respValid(mem_respValid), .mem_rdata(mem_rdata),
        .busy(busy), .owner(owner)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------------------------------------------------------- queues
    typedef struct {
        int                cyc;
        logic [ADDR_W-1:0] addr;
        logic              wen;
        logic [DATA_W-1:0] wdata;
        logic [MASK_W-1:0] wmask;
    } iss_t;
    typedef struct {
        int                cyc;
        logic              side;
        logic [DATA_W-1:0] data;
    } rsp_t;

    iss_t iss_q[$];
    rsp_t rsp_q[$];
    logic grant_log[$];

    // Model's view of what the outputs should be this cycle.
    bit                e_valid = 0;
    logic              e_busy, e_owner, e_wen;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata;
    logic [MASK_W-1:0] e_wmask;

    // ---------------------------------------------------- reference model
    // Transaction view: at most one transaction is alive; it is granted on a
    // cycle where nothing is alive, issued the cycle after, and retired by the
    // first memory response that follows the issue.
    initial begin
        bit                known = 0, alive = 0, issued = 0, withdrawn = 0;
        logic              who = 1'b1, last = 1'b1, wen = 1'b0;
        logic [ADDR_W-1:0] addr = '0;
        logic [DATA_W-1:0] wdata = '0;
        logic [MASK_W-1:0] wmask = '0;
        logic              req_of_owner;
        forever begin
            @(negedge clock);
            e_valid = known; e_busy = alive; e_owner = who;
            e_addr = addr; e_wen = wen; e_wdata = wdata; e_wmask = wmask;
            if (known && alive) begin
                if (!issued)
                    iss_q.push_back('{cyc, addr, wen, wdata, wmask});
                else if (mem_respValid && !withdrawn)
                    rsp_q.push_back('{cyc, who, mem_rdata});
            end
            req_of_owner = who ? lsu_reqValid : ifu_reqValid;
            if (reset) begin
                known = 1; alive = 0; issued = 0; withdrawn = 0;
                who = 1'b1; last = 1'b1;
                addr = '0; wen = 1'b0; wdata = '0; wmask = '0;
            end else if (known) begin
                if (!alive) begin
                    if (ifu_reqValid || lsu_reqValid) begin
                        who = (ifu_reqValid && lsu_reqValid) ? ~last : lsu_reqValid;
                        addr  = who ? lsu_addr : ifu_addr;
                        wen   = who ? lsu_wen : 1'b0;
                        wdata = who ? lsu_wdata : '0;
                        wmask = who ? lsu_wmask : '0;
                        alive = 1; issued = 0; withdrawn = 0;
                    end
                end else if (!issued) begin
                    issued = 1;
                    if (!req_of_owner) withdrawn = 1;
                end else if (mem_respValid) begin
                    last = who; alive = 0;
                end else if (!req_of_owner) begin
                    withdrawn = 1;
                end
            end
        end
    end

    // --------------------------------------------------------------- monitor
    int ifu_strobes = 0;
    int lsu_strobes = 0;
    initial begin
        iss_t e;
        rsp_t r;
        forever begin
            @(negedge clock);
            #1;
            if (e_valid) begin
                while (iss_q.size() > 0 && iss_q[0].cyc < cyc) begin
                    e = iss_q.pop_front();
                    chk("issue_missing_at_cycle", 64'(cyc), 64'(e.cyc));
                end
                while (rsp_q.size() > 0 && rsp_q[0].cyc < cyc) begin
                    r = rsp_q.pop_front();
                    chk("resp_missing_at_cycle", 64'(cyc), 64'(r.cyc));
                end
                if (mem_reqValid) begin
                    grant_log.push_back(owner);
                    if (iss_q.size() == 0) begin
                        chk("spurious_issue", 64'(mem_reqValid), 64'd0);
                    end else begin
                        e = iss_q.pop_front();
                        chk("issue_cycle", 64'(cyc), 64'(e.cyc));
                        chk("issue_addr", 64'(mem_addr), 64'(e.addr));
                        chk("issue_wen", 64'(mem_wen), 64'(e.wen));
                        chk("issue_wdata", 64'(mem_wdata), 64'(e.wdata));
                        chk("issue_wmask", 64'(mem_wmask), 64'(e.wmask));
                    end
                end
                chk("resp_exclusive", 64'(ifu_respValid & lsu_respValid), 64'd0);
                if (ifu_respValid || lsu_respValid) begin
                    if (rsp_q.size() == 0) begin
                        chk("spurious_resp", 64'(ifu_respValid | lsu_respValid), 64'd0);
                    end else begin
                        r = rsp_q.pop_front();
                        chk("resp_cycle", 64'(cyc), 64'(r.cyc));
                        chk("resp_side", 64'(lsu_respValid), 64'(r.side));
                        chk("resp_data", 64'(lsu_respValid ? lsu_rdata : ifu_rdata), 64'(r.data));
                    end
                end
                chk("busy", 64'(busy), 64'(e_busy));
                chk("owner", 64'(owner), 64'(e_owner));
                chk("hold_addr", 64'(mem_addr), 64'(e_addr));
                chk("hold_wen", 64'(mem_wen), 64'(e_wen));
                chk("hold_wdata", 64'(mem_wdata), 64'(e_wdata));
                chk("hold_wmask", 64'(mem_wmask), 64'(e_wmask));
                if (!e_busy) chk("idle_no_issue", 64'(mem_reqValid), 64'd0);
            end
            if (ifu_respValid) ifu_strobes++;
            if (lsu_respValid) lsu_strobes++;
        end
    end

    // ------------------------------------------------------- memory responder
    bit                rand_mode = 0;
    int                fix_delay = 2;
    logic [DATA_W-1:0] fix_data  = 32'h0000_0013;
    int                stray_cnt = 0;
    logic [DATA_W-1:0] stray_data = '0;
    initial begin
        int cnt = 0;
        int stray_done = 0;
        forever begin
            @(posedge clock);
            #2;
            mem_respValid = 1'b0;
            if (reset) begin
                cnt = 0;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    mem_respValid = 1'b1;
                    mem_rdata = rand_mode ? $urandom : fix_data;
                end
            end
            if (!reset && mem_reqValid)
                cnt = rand_mode ? int'($urandom_range(1, 4)) : fix_delay;
            if (stray_done != stray_cnt) begin
                stray_done++;
                mem_respValid = 1'b1;
                mem_rdata = stray_data;
            end
        end
    end

    // --------------------------------------------------------------- helpers
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ifu_reqValid = 1'b0;
        lsu_reqValid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_resp(input bit side, input int limit, output logic [DATA_W-1:0] data);
        bit seen = 0;
        data = '0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clock);
            seen = side ? lsu_respValid : ifu_respValid;
            data = side ? lsu_rdata : ifu_rdata;
            tick();
        end
        chk(side ? "lsu_resp_timeout" : "ifu_resp_timeout", 64'(seen), 64'd1);
    endtask

    task automatic drain(input int limit);
        bit idle = 0;
        ifu_reqValid = 1'b0;
        lsu_reqValid = 1'b0;
        for (int i = 0; i < limit && !idle; i++) begin
            @(negedge clock);
            idle = !busy;
            tick();
        end
        chk("drain_timeout", 64'(idle), 64'd1);
    endtask

    // Drives until each side has seen its own strobe, dropping that side then.
    task automatic serve_both(input int limit);
        bit is, ls;
        for (int i = 0; i < limit && (ifu_reqValid || lsu_reqValid); i++) begin
            @(negedge clock);
            is = ifu_respValid;
            ls = lsu_respValid;
            tick();
            if (is) ifu_reqValid = 1'b0;
            if (ls) lsu_reqValid = 1'b0;
        end
        chk("serve_timeout", 64'(ifu_reqValid | lsu_reqValid), 64'd0);
    endtask

    // ------------------------------------------------------------------ main
    initial begin
        logic [DATA_W-1:0] d;
        int base, s_ifu, s_lsu;
        bit ifu_act = 0, lsu_act = 0, ifu_str, lsu_str;

        tick();
        do_reset();

        // Single ifu fetch with a 2-cycle memory.
        ifu_addr = 32'h8000_0000;
        ifu_reqValid = 1'b1;
        wait_resp(0, 20, d);
        ifu_reqValid = 1'b0;
        chk("t1_rdata", 64'(d), 64'h13);
        chk("t1_lsu_quiet", 64'(lsu_strobes), 64'd0);

        // Tie from reset: ifu first, then the lsu store.
        do_reset();
        base = grant_log.size();
        ifu_addr = 32'h0000_0200; ifu_reqValid = 1'b1;
        lsu_addr = 32'h0000_0100; lsu_wen = 1'b1;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF; lsu_reqValid = 1'b1;
        serve_both(40);
        chk("t2_grants", 64'(grant_log.size() - base), 64'd2);
        if (grant_log.size() - base == 2) begin
            chk("t2_first_ifu", 64'(grant_log[base]), 64'd0);
            chk("t2_second_lsu", 64'(grant_log[base + 1]), 64'd1);
        end

        // Both held continuously: strict alternation over six transactions.
        do_reset();
        base = grant_log.size();
        lsu_wen = 1'b0;
        ifu_reqValid = 1'b1; lsu_reqValid = 1'b1;
        for (int i = 0; i < 80 && grant_log.size() - base < 6; i++) tick();
        drain(30);
        chk("t3_enough_grants", 64'(grant_log.size() - base >= 6), 64'd1);
        if (grant_log.size() - base >= 6)
            for (int i = 0; i < 6; i++)
                chk("t3_alternate", 64'(grant_log[base + i]), 64'(i % 2));

        // ifu withdraws while waiting; its response is swallowed, lsu goes next.
        do_reset();
        base = grant_log.size();
        s_ifu = ifu_strobes;
        fix_delay = 4;
        ifu_addr = 32'h0000_0300; ifu_reqValid = 1'b1;
        lsu_addr = 32'h0000_0400; lsu_reqValid = 1'b1;
        tick(); tick(); tick();
        ifu_reqValid = 1'b0;
        wait_resp(1, 30, d);
        lsu_reqValid = 1'b0;
        drain(20);
        chk("t4_ifu_dropped", 64'(ifu_strobes - s_ifu), 64'd0);
        chk("t4_grants", 64'(grant_log.size() - base), 64'd2);
        if (grant_log.size() - base == 2)
            chk("t4_lsu_next", 64'(grant_log[base + 1]), 64'd1);

        // Stray response while idle.
        s_ifu = ifu_strobes; s_lsu = lsu_strobes;
        stray_data = 32'h0000_1234;
        stray_cnt++;
        tick(); tick(); tick();
        chk("t5_no_ifu", 64'(ifu_strobes - s_ifu), 64'd0);
        chk("t5_no_lsu", 64'(lsu_strobes - s_lsu), 64'd0);
        chk("t5_idle", 64'(busy), 64'd0);

        // Reset while waiting, stray response right after release, then recover.
        fix_delay = 10;
        ifu_addr = 32'h0000_0040; ifu_reqValid = 1'b1;
        tick(); tick(); tick();
        s_ifu = ifu_strobes;
        reset = 1'b1; ifu_reqValid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        stray_data = 32'hBAD0_0001;
        stray_cnt++;
        tick(); tick();
        chk("t6_stray_ignored", 64'(ifu_strobes - s_ifu), 64'd0);
        chk("t6_idle", 64'(busy), 64'd0);
        fix_delay = 2; fix_data = 32'h0000_0A0A;
        ifu_addr = 32'h0000_0044; ifu_reqValid = 1'b1;
        wait_resp(0, 20, d);
        ifu_reqValid = 1'b0;
        chk("t6_recover_data", 64'(d), 64'h0A0A);

        // Randomized traffic with occasional withdrawals.
        drain(20);
        rand_mode = 1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            ifu_str = ifu_respValid;
            lsu_str = lsu_respValid;
            tick();
            if (ifu_act && (ifu_str || $urandom_range(0, 39) == 0)) begin
                ifu_act = 0; ifu_reqValid = 1'b0;
            end
            if (lsu_act && (lsu_str || $urandom_range(0, 39) == 0)) begin
                lsu_act = 0; lsu_reqValid = 1'b0;
            end
            if (!ifu_act && $urandom_range(0, 2) == 0) begin
                ifu_act = 1; ifu_addr = $urandom & 32'hFFFF_FFFC; ifu_reqValid = 1'b1;
            end
            if (!lsu_act && $urandom_range(0, 2) == 0) begin
                lsu_act = 1; lsu_addr = $urandom; lsu_wen = 1'($urandom);
                lsu_wdata = $urandom; lsu_wmask = 4'($urandom); lsu_reqValid = 1'b1;
            end
        end
        drain(30);
        tick(); tick();

        chk("issue_queue_empty", 64'(iss_q.size()), 64'd0);
        chk("resp_queue_empty", 64'(rsp_q.size()), 64'd0);
        chk("random_saw_ifu", 64'(ifu_strobes > 5), 64'd1);
        chk("random_saw_lsu", 64'(lsu_strobes > 5), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
`default_nettype wire
